sgbm_wta: RTL and testbench

Winner-take-all disparity selector consuming the aggregated-cost stream produced by the SGBM calculation core (`cost_aggr`/`aggr_row`/`aggr_col`/`aggr_valid`). For every valid pixel it finds the minimum-cost disparity through a fully pipelined comparison tree. It applies a uniqueness check against the second-best cost and emits one disparity per pixel with its coordinates. It also counts rejected pixels per frame and pulses a frame-done flag on the last pixel.

---
 rtl/sgbm_wta_if.sv | 28 ++
 rtl/sgbm_wta.sv | 133 +++++++++++++
 tb/tb_sgbm_wta.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sgbm_wta_if.sv
// Stream bundle for the WTA selector: aggregated-cost pixel in, disparity out.
interface sgbm_wta_if #(
  parameter int DISP   = 96,
  parameter int COST_W = 9
);
  logic [DISP*COST_W-1:0] cost_in;
  logic [9:0]             row_in;
  logic [9:0]             col_in;
  logic                   valid_in;

  logic [6:0]             disp_out;
  logic                   disp_ok;
  logic [9:0]             disp_row;
  logic [9:0]             disp_col;
  logic                   disp_valid;
  logic                   frame_done;
  logic [16:0]            reject_count;

  modport master (
    output cost_in, row_in, col_in, valid_in,
    input  disp_out, disp_ok, disp_row, disp_col, disp_valid, frame_done, reject_count
  );

  modport slave (
    input  cost_in, row_in, col_in, valid_in,
    output disp_out, disp_ok, disp_row, disp_col, disp_valid, frame_done, reject_count
  );
endinterface

// File: rtl/sgbm_wta.sv
// Winner-take-all disparity selector: 7-stage registered min tree carrying
// (min, idx, second-min), uniqueness check, per-frame reject counter.
module sgbm_wta #(
  parameter int               DISP      = 96,
  parameter int               COST_W    = 9,
  parameter int               IMAGE_ROW = 200,
  parameter int               IMAGE_COL = 400,
  parameter logic [COST_W-1:0] UNIQ_TH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  sgbm_wta_if.slave  bus
);
  localparam int LANES  = 128;
  localparam int STAGES = 7;
  localparam logic [COST_W-1:0] MAX_COST = '1;

  typedef struct packed {
    logic [COST_W-1:0] min;
    logic [6:0]        idx;
    logic [COST_W-1:0] min2;
  } node_t;

  // a-side always holds the lower lane indices, so a wins ties
  function automatic node_t merge(input node_t a, input node_t b);
    node_t             r;
    logic [COST_W-1:0] hi;
    if (b.min < a.min) begin
      r.min = b.min; r.idx = b.idx; hi = a.min;
    end else begin
      r.min = a.min; r.idx = a.idx; hi = b.min;
    end
    r.min2 = (a.min2 < b.min2) ? a.min2 : b.min2;
    if (hi < r.min2) r.min2 = hi;
    return r;
  endfunction

  // pad lanes get the maximum cost so a real lane always beats them on ties
  logic [LANES*COST_W-1:0] cost_pad;
  assign cost_pad = {{((LANES-DISP)*COST_W){1'b1}}, bus.cost_in};

  node_t leaf [LANES];
  node_t st_d [1:STAGES][LANES/2];
  node_t st_q [1:STAGES][LANES/2];

  // leaf nodes: one per padded lane
  always_comb begin
    for (int d = 0; d < LANES; d++) begin
      leaf[d].min  = cost_pad[COST_W*d +: COST_W];
      leaf[d].idx  = 7'(d);
      leaf[d].min2 = MAX_COST;
    end
  end

  // next-state of every tree level; unused upper slots stay zero
  always_comb begin
    st_d = '{default: '0};
    for (int n = 0; n < LANES/2; n++)
      st_d[1][n] = merge(leaf[2*n], leaf[2*n+1]);
    for (int l = 2; l <= STAGES; l++)
      for (int n = 0; n < (LANES >> l); n++)
        st_d[l][n] = merge(st_q[l-1][2*n], st_q[l-1][2*n+1]);
  end

  // tree data registers run free; only the valid pipe qualifies them
  always_ff @(posedge clk) st_q <= st_d;

  logic [STAGES:1] vld_pipe;
  logic [9:0]      row_pipe [1:STAGES];
  logic [9:0]      col_pipe [1:STAGES];

  // valid bits are the only pipeline state that must clear on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid_in};
  end

  // coordinates ride alongside the tree at identical depth
  always_ff @(posedge clk) begin
    row_pipe[1] <= bus.row_in;
    col_pipe[1] <= bus.col_in;
    for (int k = 2; k <= STAGES; k++) begin
      row_pipe[k] <= row_pipe[k-1];
      col_pipe[k] <= col_pipe[k-1];
    end
  end

  node_t         root;
  logic [COST_W:0] margin;
  logic          ok_d, rej_d, last_d;
  logic [16:0]   cnt;
  logic [17:0]   cnt_inc;
  logic [16:0]   cnt_nxt;

  // uniqueness decision, last-pixel decode and saturating reject increment
  always_comb begin
    root    = st_q[STAGES][0];
    margin  = {1'b0, root.min2} - {1'b0, root.min};
    ok_d    = margin >= {1'b0, UNIQ_TH};
    rej_d   = vld_pipe[STAGES] && !ok_d;
    last_d  = vld_pipe[STAGES] && (row_pipe[STAGES] == 10'(IMAGE_ROW-1)) &&
              (col_pipe[STAGES] == 10'(IMAGE_COL-1));
    cnt_inc = {1'b0, cnt} + {17'd0, rej_d};
    cnt_nxt = cnt_inc[17] ? '1 : cnt_inc[16:0];
  end

  // registered outputs and the frame reject counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.disp_out     <= '0;
      bus.disp_ok      <= 1'b0;
      bus.disp_row     <= '0;
      bus.disp_col     <= '0;
      bus.disp_valid   <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.reject_count <= '0;
      cnt              <= '0;
    end else begin
      bus.disp_valid <= vld_pipe[STAGES];
      bus.disp_ok    <= vld_pipe[STAGES] && ok_d;
      bus.disp_out   <= (vld_pipe[STAGES] && ok_d) ? root.idx : 7'd0;
      bus.disp_row   <= row_pipe[STAGES];
      bus.disp_col   <= col_pipe[STAGES];
      bus.frame_done <= last_d;
      if (last_d) begin
        bus.reject_count <= cnt_nxt;
        cnt              <= '0;
      end else begin
        cnt <= cnt_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sgbm_wta.sv
// Directed + small-frame streaming bench for sgbm_wta with a scoreboard queue.
module tb_sgbm_wta;
  localparam int DISP = 96, COST_W = 9, NR = 4, NC = 5, CW = DISP*COST_W;

  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  sgbm_wta_if #(.DISP(DISP), .COST_W(COST_W)) bus();
  sgbm_wta #(.DISP(DISP), .COST_W(COST_W), .IMAGE_ROW(NR), .IMAGE_COL(NC),
             .UNIQ_TH(9'd4)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ref_cnt = 0, fd_seen = 0;
  bit mon_en = 0;

  typedef struct { int bg; int la; int ca; int lb; int cb; int disp; int ok; } vec_t;
  typedef struct { int cyc; int disp; int ok; int row; int col; int fd; int rc; } exp_t;
  vec_t vt[9];
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int bg, input int la, input int ca,
                                       input int lb, input int cb);
    logic [CW-1:0] v;
    for (int d = 0; d < DISP; d++) v[COST_W*d +: COST_W] = COST_W'(bg);
    v[COST_W*la +: COST_W] = COST_W'(ca);
    v[COST_W*lb +: COST_W] = COST_W'(cb);
    return v;
  endfunction

  // reference: lowest-index minimum, then smallest cost of any other lane
  task automatic ref_px(input logic [CW-1:0] c, output int disp, output int ok);
    int m, id, m2, v;
    m = 1024; id = 0; m2 = 511;
    for (int d = 0; d < DISP; d++) begin
      v = int'(c[COST_W*d +: COST_W]);
      if (v < m) begin m = v; id = d; end
    end
    for (int d = 0; d < DISP; d++) begin
      v = int'(c[COST_W*d +: COST_W]);
      if (d != id && v < m2) m2 = v;
    end
    ok   = (m2 - m >= 4) ? 1 : 0;
    disp = ok ? id : 0;
  endtask

  task automatic rnd_px(input int i, output logic [CW-1:0] c);
    int w, w2;
    for (int d = 0; d < DISP; d++) c[COST_W*d +: COST_W] = COST_W'($urandom_range(511, 60));
    w = $urandom_range(95, 0);
    c[COST_W*w +: COST_W] = COST_W'($urandom_range(70, 0));
    if (i % 3 == 0) begin
      w2 = (w + 1 + $urandom_range(93, 0)) % DISP;
      c[COST_W*w2 +: COST_W] = c[COST_W*w +: COST_W];
    end
  endtask

  task automatic send(input logic [CW-1:0] c, input int row, input int col);
    exp_t e; int d, o;
    @(negedge clk);
    bus.cost_in = c; bus.row_in = 10'(row); bus.col_in = 10'(col); bus.valid_in = 1;
    ref_px(c, d, o);
    e.cyc = cyc + 8; e.disp = d; e.ok = o; e.row = row; e.col = col;
    e.fd = (row == NR-1 && col == NC-1) ? 1 : 0;
    if (o == 0) ref_cnt++;
    e.rc = 0;
    if (e.fd != 0) begin e.rc = ref_cnt; ref_cnt = 0; end
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid_in = 0;
  endtask

  // scoreboard: valid must appear exactly in the expected cycle
  always @(posedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit   ev;
      #3;
      ev = (q.size() > 0) && (q[0].cyc == cyc);
      chk("valid", int'(bus.disp_valid), int'(ev));
      chk("frame_done", int'(bus.frame_done), ev ? q[0].fd : 0);
      if (ev) begin
        e = q.pop_front();
        chk("disp_out", int'(bus.disp_out), e.disp);
        chk("disp_ok", int'(bus.disp_ok), e.ok);
        chk("disp_row", int'(bus.disp_row), e.row);
        chk("disp_col", int'(bus.disp_col), e.col);
        if (e.fd != 0) begin
          chk("reject_count", int'(bus.reject_count), e.rc);
          fd_seen++;
        end
      end
    end
  end

  initial begin
    logic [CW-1:0] c;
    vt[0] = '{100, 37,  10, 37,  10, 37, 1};
    vt[1] = '{300,  5,  20, 60,  20,  0, 0};
    vt[2] = '{300,  5,  20, 60,  23,  0, 0};
    vt[3] = '{300,  5,  20, 60,  24,  5, 1};
    vt[4] = '{511,  0, 511,  0, 511,  0, 0};
    vt[5] = '{511, 95,   0, 95,   0, 95, 1};
    vt[6] = '{200,  0, 196,  0, 196,  0, 1};
    vt[7] = '{200, 95, 197, 95, 197,  0, 0};
    vt[8] = '{511, 63,   7, 64,   3, 64, 1};

    bus.cost_in = '0; bus.row_in = '0; bus.col_in = '0; bus.valid_in = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.disp_valid), 0);
    chk("rst_disp", int'(bus.disp_out), 0);
    chk("rst_ok", int'(bus.disp_ok), 0);
    chk("rst_row", int'(bus.disp_row), 0);
    chk("rst_col", int'(bus.disp_col), 0);
    chk("rst_fdone", int'(bus.frame_done), 0);
    chk("rst_rcount", int'(bus.reject_count), 0);
    @(negedge clk) rst = 1;
    repeat (2) @(negedge clk);

    // directed single pixels: latency exactly 8, quiet on 7 and 9
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.cost_in  = mk(vt[i].bg, vt[i].la, vt[i].ca, vt[i].lb, vt[i].cb);
      bus.row_in   = 10'(i*3 + 1);
      bus.col_in   = 10'(i*7 + 2);
      bus.valid_in = 1;
      @(posedge clk);
      #1 bus.valid_in = 0;
      repeat (6) @(posedge clk);
      #1 chk("dir_valid_c7", int'(bus.disp_valid), 0);
      @(posedge clk);
      #1;
      chk("dir_valid_c8", int'(bus.disp_valid), 1);
      chk("dir_disp", int'(bus.disp_out), vt[i].disp);
      chk("dir_ok", int'(bus.disp_ok), vt[i].ok);
      chk("dir_row", int'(bus.disp_row), i*3 + 1);
      chk("dir_col", int'(bus.disp_col), i*7 + 2);
      chk("dir_fdone", int'(bus.frame_done), 0);
      @(posedge clk);
      #1 chk("dir_valid_c9", int'(bus.disp_valid), 0);
      if (vt[i].ok == 0) ref_cnt++;
    end

    // two back-to-back random frames
    mon_en = 1;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NR; r++)
        for (int cl = 0; cl < NC; cl++) begin
          rnd_px(r*NC + cl, c);
          send(c, r, cl);
        end
    idle();
    repeat (12) @(posedge clk);
    chk("frame_done_count", fd_seen, 2);

    // reset while the pipe is full and outputs are streaming
    for (int i = 0; i < 9; i++) begin
      rnd_px(i + 1, c);
      send(c, 0, i);
    end
    @(negedge clk);
    rst = 0; bus.valid_in = 0;
    q.delete(); ref_cnt = 0;
    #1;
    chk("midrst_valid", int'(bus.disp_valid), 0);
    chk("midrst_rcount", int'(bus.reject_count), 0);
    chk("midrst_disp", int'(bus.disp_out), 0);
    @(negedge clk);
    @(negedge clk) rst = 1;
    repeat (10) idle();
    send(mk(100, 37, 10, 37, 10), 2, 3);
    idle();
    repeat (12) @(posedge clk);

    // valid gaps 1,0,1,1,0 pass through unchanged
    send(mk(300, 5, 20, 60, 24), 1, 1);
    idle();
    send(mk(511, 95, 0, 95, 0), 1, 2);
    send(mk(300, 5, 20, 60, 20), 1, 3);
    idle();
    repeat (12) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
